handshake_ctrl_sink_fifo: RTL and testbench

- Reverse of a constant unit: consumes data tokens on an elastic data channel and emits one dataless control token per consumed token on an elastic control channel.
- Data values are discarded. Buffering is a token counter, not a storage array, so it decouples producer and consumer by up to DEPTH tokens.
- Sits where the dataflow graph converts a data result into a control/sequencing token, e.g. loop-exit or store-done signalling.
- Also exposes occupancy and a saturating retired-token count for performance monitors.

---
 rtl/handshake_ctrl_sink_fifo_if.sv | 38 +++
 rtl/handshake_ctrl_sink_fifo.sv | 71 +++++++
 tb/tb_handshake_ctrl_sink_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_ctrl_sink_fifo_if.sv
// handshake_ctrl_sink_fifo_if
// Bundles the elastic data input channel and the dataless control output
// channel of handshake_ctrl_sink_fifo.
//   ins        : data payload (ignored by the sink)
//   ins_valid  : producer offers a data token
//   ins_ready  : sink can accept a data token
//   outs_valid : sink offers a control token
//   outs_ready : consumer accepts the control token
// Modports:
//   master : the environment side (drives data, accepts control tokens)
//   slave  : the sink block itself
interface handshake_ctrl_sink_fifo_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins,
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs_valid
  );

  modport slave (
    input  ins,
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs_valid
  );

endinterface

// File: rtl/handshake_ctrl_sink_fifo.sv
// handshake_ctrl_sink_fifo
// Consumes data tokens and emits one dataless control token per consumed
// token. Data values are thrown away, so the buffer is just a token counter
// that decouples producer and consumer by up to DEPTH tokens. Also reports
// occupancy and a saturating count of delivered control tokens.
// Ports:
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset, drops all buffered tokens
//   bus           : slave view of the data-in / control-out handshake pair
//   occupancy     : number of control tokens currently buffered
//   retired_count : control tokens delivered since reset, saturating
// DEPTH must lie in 1..255.
module handshake_ctrl_sink_fifo #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 4,
  parameter  int COUNT_WIDTH = 16,
  localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  handshake_ctrl_sink_fifo_if.slave  bus,
  output logic [CNT_WIDTH-1:0]       occupancy,
  output logic [COUNT_WIDTH-1:0]     retired_count
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0]   cnt;
  logic [COUNT_WIDTH-1:0] retired;
  logic                   push;
  logic                   pop;

  // The payload never reaches any state or output; it is tapped here only
  // so that the width is consumed, and X/Z on it cannot leak anywhere.
  logic [DATA_WIDTH-1:0]  unused_ins;
  assign unused_ins = bus.ins;

  // Handshake outputs come from the counter alone. This keeps outs_ready
  // off the ins_ready path and ins_valid off the outs_valid path, at the
  // cost of a full buffer refusing input even while it is being drained.
  assign bus.ins_ready  = (cnt != FULL);
  assign bus.outs_valid = (cnt != '0);
  assign occupancy      = cnt;
  assign retired_count  = retired;

  assign push = bus.ins_valid & bus.ins_ready;
  assign pop  = bus.outs_valid & bus.outs_ready;

  // Token counter: a simultaneous push and pop cancel out, which is what
  // gives full throughput whenever the buffer is neither empty nor full.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // Delivered-token statistic; sticks at all-ones instead of wrapping so a
  // monitor never sees a small count after a long run.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (pop && (retired != '1)) begin
      retired <= retired + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_handshake_ctrl_sink_fifo.sv
// tb_handshake_ctrl_sink_fifo
// Drives four sink instances from one shared stimulus:
//   0 : DEPTH=4, COUNT_WIDTH=16
//   1 : DEPTH=2, COUNT_WIDTH=16
//   2 : DEPTH=1, COUNT_WIDTH=16
//   3 : DEPTH=4, COUNT_WIDTH=4 (saturating statistic)
// A per-instance scoreboard queue holds the acceptance ordinal of every
// buffered token; when a control token leaves, its ordinal is the expected
// (saturated) retired count.
module tb_handshake_ctrl_sink_fifo;

  localparam int NDUT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic        ready_o [NDUT];
  logic        valid_o [NDUT];
  logic [31:0] occ_o   [NDUT];
  logic [31:0] ret_o   [NDUT];

  int dep_c [NDUT] = '{4, 2, 1, 4};
  int max_c [NDUT] = '{65535, 65535, 65535, 15};

  int exp_q [NDUT][$];
  int m_acc [NDUT];
  int m_del [NDUT];
  int m_ret [NDUT];

  int checks;
  int passes;
  int fails;
  int sat_pops;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DEP = (g == 1) ? 2 : ((g == 2) ? 1 : 4);
    localparam int CW  = (g == 3) ? 4 : 16;

    logic [$clog2(DEP+1)-1:0] occ;
    logic [CW-1:0]            ret;

    handshake_ctrl_sink_fifo_if #(.DATA_WIDTH(32)) bus ();

    assign bus.ins        = ins;
    assign bus.ins_valid  = ins_valid;
    assign bus.outs_ready = outs_ready;

    handshake_ctrl_sink_fifo #(
      .DATA_WIDTH  (32),
      .DEPTH       (DEP),
      .COUNT_WIDTH (CW)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .occupancy     (occ),
      .retired_count (ret)
    );

    assign ready_o[g] = bus.ins_ready;
    assign valid_o[g] = bus.outs_valid;
    assign occ_o[g]   = 32'(occ);
    assign ret_o[g]   = 32'(ret);
  end

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check every instance against its model away from the
  // edge, then advance the models on the rising edge.
  task automatic apply_stimulus();
    bit push [NDUT];
    bit pop  [NDUT];
    bit e_ready;
    bit e_valid;
    int seq;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      e_ready = (exp_q[i].size() < dep_c[i]);
      e_valid = (exp_q[i].size() != 0);
      check_output($sformatf("ins_ready[%0d]", i), 32'(ready_o[i]), 32'(e_ready));
      check_output($sformatf("outs_valid[%0d]", i), 32'(valid_o[i]), 32'(e_valid));
      check_output($sformatf("occupancy[%0d]", i), occ_o[i], 32'(exp_q[i].size()));
      check_output($sformatf("retired[%0d]", i), ret_o[i], 32'(m_ret[i]));
      check_output($sformatf("conservation[%0d]", i), 32'(m_acc[i]) - occ_o[i],
                   32'(m_del[i]));
      push[i] = ins_valid && e_ready;
      pop[i]  = e_valid && outs_ready;
    end
    if (valid_o[3] === 1'b1 && outs_ready === 1'b1 && rst === 1'b0) sat_pops++;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        exp_q[i].delete();
        m_acc[i] = 0;
        m_del[i] = 0;
        m_ret[i] = 0;
      end else begin
        if (pop[i]) begin
          seq      = exp_q[i].pop_front();
          m_del[i] = m_del[i] + 1;
          m_ret[i] = (seq > max_c[i]) ? max_c[i] : seq;
        end
        if (push[i]) begin
          m_acc[i] = m_acc[i] + 1;
          exp_q[i].push_back(m_acc[i]);
        end
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int occ_fill [6] = '{1, 2, 3, 4, 4, 4};
    checks   = 0;
    passes   = 0;
    fails    = 0;
    sat_pops = 0;
    for (int i = 0; i < NDUT; i++) begin
      m_acc[i] = 0;
      m_del[i] = 0;
      m_ret[i] = 0;
    end

    // Reset for two cycles, then idle.
    rst        = 1'b1;
    ins        = 32'h0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_ins_ready", 32'(ready_o[0]), 32'd1);
    check_output("rst_outs_valid", 32'(valid_o[0]), 32'd0);
    check_output("rst_occupancy", occ_o[0], 32'd0);
    check_output("rst_retired", ret_o[0], 32'd0);
    apply_stimulus();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) apply_stimulus();

    // Fill with a stalled consumer.
    ins_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ins = (c == 0) ? 32'hDEADBEEF : 32'(c);
      apply_stimulus();
      check_output($sformatf("fill_occ_%0d", c), occ_o[0], 32'(occ_fill[c]));
      check_output($sformatf("fill_ready_%0d", c), 32'(ready_o[0]), (c < 3) ? 32'd1 : 32'd0);
      check_output($sformatf("fill_valid_%0d", c), 32'(valid_o[0]), 32'd1);
    end

    // Drain from full: first cycle is pop only, then push+pop each cycle.
    outs_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus();
      check_output($sformatf("drain_occ_%0d", c), occ_o[0], 32'd3);
      check_output($sformatf("drain_ret_%0d", c), ret_o[0], 32'(c + 1));
    end

    // Streaming throughput from empty.
    rst       = 1'b1;
    ins_valid = 1'b0;
    apply_stimulus();
    rst       = 1'b0;
    ins_valid = 1'b1;
    for (int c = 0; c < 100; c++) apply_stimulus();
    check_output("stream_d4_ret", ret_o[0], 32'd99);
    check_output("stream_d2_ret", ret_o[1], 32'd99);
    check_output("stream_d2_occ", occ_o[1], 32'd1);
    check_output("stream_d1_ret", ret_o[2], 32'd50);
    check_output("stream_d1_occ", occ_o[2], 32'd0);

    // Reset in the middle of operation with traffic on both channels.
    rst = 1'b1;
    apply_stimulus();
    rst        = 1'b0;
    outs_ready = 1'b0;
    for (int c = 0; c < 3; c++) apply_stimulus();
    check_output("midrst_pre_occ", occ_o[0], 32'd3);
    rst        = 1'b1;
    outs_ready = 1'b1;
    apply_stimulus();
    check_output("midrst_occ", occ_o[0], 32'd0);
    check_output("midrst_valid", 32'(valid_o[0]), 32'd0);
    check_output("midrst_ret", ret_o[0], 32'd0);
    rst       = 1'b0;
    ins_valid = 1'b0;
    apply_stimulus();
    check_output("midrst_after_ret", ret_o[0], 32'd0);

    // Saturation of the 4-bit statistic under random back-pressure, with
    // the payload driven unknown throughout.
    ins      = 'x;
    sat_pops = 0;
    for (int c = 0; c < 400 && sat_pops < 20; c++) begin
      ins_valid  = ($urandom_range(0, 2) != 0);
      outs_ready = ($urandom_range(0, 2) != 0);
      apply_stimulus();
    end
    check_output("sat_pops_reached", 32'(sat_pops >= 20), 32'd1);
    check_output("sat_ret", ret_o[3], 32'd15);
    ins_valid  = 1'b1;
    outs_ready = 1'b1;
    for (int c = 0; c < 4; c++) apply_stimulus();
    check_output("sat_hold", ret_o[3], 32'd15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
